// File: rtl/spacedash_pkg.sv
// Shared constants and types for the spaceDash button front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spacedash_pkg;

    localparam int unsigned NUM_BTN = 4;

    // Channel index of each physical button on the GPIO header
    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_FIRE  = 2;
    localparam int unsigned BTN_START = 3;

    // Auto-repeat state: waiting for a press, or holding and counting
    typedef enum logic {
        RPT_IDLE = 1'b0,
        RPT_HOLD = 1'b1
    } rpt_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw pins and conditioned button outputs between board wrapper and game.
// Latency: n/a (wires only).
// Backpressure: none; every output is a level or a single-cycle strobe.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = spacedash_pkg::NUM_BTN
);
    logic [NUM_BTN-1:0] btn_raw_n;    // raw pins, active-low, asynchronous
    logic [NUM_BTN-1:0] btn_level;    // debounced level, 1 = pressed
    logic [NUM_BTN-1:0] btn_press;    // one-cycle strobe on accepted press
    logic [NUM_BTN-1:0] btn_release;  // one-cycle strobe on accepted release
    logic [NUM_BTN-1:0] btn_repeat;   // one-cycle auto-repeat strobe while held

    // Pin side drives the raw inputs and observes the conditioned outputs
    modport master (
        output btn_raw_n,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    // Conditioner side
    modport slave (
        input  btn_raw_n,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter, optional auto-repeat FSM.
// Latency: pin edge to level/press/release is 2 + DEBOUNCE_CYC cycles.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
module btn_channel
    import spacedash_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter bit          REPEAT_EN     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    // A one-cycle debounce window still needs a 1-bit counter
    localparam int unsigned  DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          sync_s;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    assign sync_s = sync_q[1];

    // Two-flop synchroniser; the pin is inverted first so 1 means pressed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ~raw_n_i};
        end
    end

    // Debounce: count consecutive cycles that disagree with the level; any agreement restarts
    always_comb begin
        dcnt_d    = dcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_s == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DMAX) begin
            dcnt_d    = '0;
            level_d   = sync_s;
            press_d   = sync_s;
            release_d = ~sync_s;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Debounce state and registered strobes, updated together with the level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    if (REPEAT_EN && (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_cfg
        $error("btn_channel: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    if (REPEAT_EN) begin : g_rpt
        // rcnt only ever reaches REPEAT_DELAY-1 before it is reloaded
        localparam int unsigned   RW      = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
        localparam logic [RW-1:0] RFIRST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RRELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

        rpt_state_t    state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          repeat_q, repeat_d;

        // Repeat FSM: a release accepted this cycle wins over a repeat that falls due
        always_comb begin
            state_d  = state_q;
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    if (press_d) begin
                        state_d = RPT_HOLD;
                        rcnt_d  = '0;
                    end
                end
                RPT_HOLD: begin
                    if (release_d) begin
                        state_d = RPT_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RFIRST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = RRELOAD;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        // Repeat FSM state register
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q  <= RPT_IDLE;
                rcnt_q   <= '0;
                repeat_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                rcnt_q   <= rcnt_d;
                repeat_q <= repeat_d;
            end
        end

        assign repeat_o = repeat_q;
    end else begin : g_no_rpt
        assign repeat_o = 1'b0;
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four spaceDash push-buttons: sync, debounce, press/release/repeat strobes.
// Latency: pin edge to level/strobe is 2 + DEBOUNCE_CYC cycles of CLOCK_50.
// Backpressure: none; consumers must sample single-cycle strobes every cycle.
module button_conditioner #(
    parameter int unsigned        NUM_BTN       = spacedash_pkg::NUM_BTN,
    parameter int unsigned        DEBOUNCE_CYC  = 500000,
    parameter int unsigned        REPEAT_DELAY  = 25000000,
    parameter int unsigned        REPEAT_PERIOD = 5000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK   = NUM_BTN'(4'b0011)
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    button_conditioner_if.slave   btn
);

    // One independent conditioner per button; repeat only where the mask enables it
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk_i     (CLOCK_50),
            .rst_i     (reset),
            .raw_n_i   (btn.btn_raw_n[i]),
            .level_o   (btn.btn_level[i]),
            .press_o   (btn.btn_press[i]),
            .release_o (btn.btn_release[i]),
            .repeat_o  (btn.btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/repeat timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_conditioner;
    import spacedash_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;

    button_conditioner_if #(.NUM_BTN(NUM_BTN)) bus ();

    button_conditioner #(
        .NUM_BTN       (NUM_BTN),
        .DEBOUNCE_CYC  (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .REPEAT_MASK   (4'b0011)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .btn      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] rp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] rp);
        exp_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.rp  = rp;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle with a strobe must match the next expected event
    always @(negedge CLOCK_50) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: expected at cycle %0d press=%b release=%b repeat=%b, nothing seen",
                     sb[0].cyc, sb[0].pr, sb[0].rl, sb[0].rp);
            void'(sb.pop_front());
        end
        if (|bus.btn_press || |bus.btn_release || |bus.btn_repeat) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event at cycle %0d: press=%b release=%b repeat=%b, expected none",
                         cyc, bus.btn_press, bus.btn_release, bus.btn_repeat);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc != cyc || mon_e.pr !== bus.btn_press ||
                    mon_e.rl !== bus.btn_release || mon_e.rp !== bus.btn_repeat) begin
                    errors++;
                    $display("FAIL event at cycle %0d: press=%b release=%b repeat=%b, expected cycle %0d press=%b release=%b repeat=%b",
                             cyc, bus.btn_press, bus.btn_release, bus.btn_repeat,
                             mon_e.cyc, mon_e.pr, mon_e.rl, mon_e.rp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        bus.btn_raw_n = 4'hF;
        reset = 1'b1;
        step(3);
        chk("reset_outputs", {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat}, 16'h0000);
        reset = 1'b0;
        step(2);

        // Clean press on LEFT, held for repeats, released so acceptance meets a due repeat
        e = cyc;
        bus.btn_raw_n[BTN_LEFT] = 1'b0;
        push(e + 6, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 10; k <= 40; k += 5) push(e + 6 + k, 4'b0000, 4'b0000, 4'b0001);
        push(e + 6 + 45, 4'b0000, 4'b0001, 4'b0000);
        step(5);
        chk("s1_level_before", 16'(bus.btn_level[BTN_LEFT]), 16'h0000);
        step(1);
        chk("s1_level_after", 16'(bus.btn_level[BTN_LEFT]), 16'h0001);
        step(39);
        bus.btn_raw_n[BTN_LEFT] = 1'b1;
        step(6);
        chk("s1_level_released", 16'(bus.btn_level[BTN_LEFT]), 16'h0000);
        step(20);

        // Bouncing FIRE pin (no auto-repeat on this channel), long hold, release
        e = cyc;
        bus.btn_raw_n[BTN_FIRE] = 1'b0;
        step(2);
        bus.btn_raw_n[BTN_FIRE] = 1'b1;
        step(2);
        bus.btn_raw_n[BTN_FIRE] = 1'b0;
        push(e + 10, 4'b0100, 4'b0000, 4'b0000);
        step(6);
        chk("s2_level_pressed", 16'(bus.btn_level[BTN_FIRE]), 16'h0001);
        step(39);
        bus.btn_raw_n[BTN_FIRE] = 1'b1;
        push(e + 55, 4'b0000, 4'b0100, 4'b0000);
        step(6);
        chk("s2_level_released", 16'(bus.btn_level[BTN_FIRE]), 16'h0000);
        step(10);

        // RIGHT held into HOLD, one-cycle reset, pin still low afterwards
        e = cyc;
        bus.btn_raw_n[BTN_RIGHT] = 1'b0;
        push(e + 6, 4'b0010, 4'b0000, 4'b0000);
        push(e + 16, 4'b0000, 4'b0000, 4'b0010);
        step(18);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("s5_outputs_after_reset", {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat}, 16'h0000);
        push(e + 25, 4'b0010, 4'b0000, 4'b0000);
        push(e + 35, 4'b0000, 4'b0000, 4'b0010);
        step(11);
        bus.btn_raw_n[BTN_RIGHT] = 1'b1;
        push(e + 36, 4'b0000, 4'b0010, 4'b0000);
        step(6);
        chk("s5_level_released", 16'(bus.btn_level[BTN_RIGHT]), 16'h0000);
        step(10);

        // All four buttons pressed and released together
        e = cyc;
        bus.btn_raw_n = 4'b0000;
        push(e + 6, 4'b1111, 4'b0000, 4'b0000);
        push(e + 16, 4'b0000, 4'b0000, 4'b0011);
        step(12);
        bus.btn_raw_n = 4'b1111;
        push(e + 18, 4'b0000, 4'b1111, 4'b0000);
        step(6);
        chk("s6_levels_released", 16'(bus.btn_level), 16'h0000);
        step(10);

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL never_seen: expected at cycle %0d press=%b release=%b repeat=%b",
                     sb[0].cyc, sb[0].pr, sb[0].rl, sb[0].rp);
            void'(sb.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
